pool1d_window_buffer: RTL

- Streaming stage directly upstream of the 1-D average pool; converts a one-element-per-beat row stream into KERNEL_SIZE-wide windows.
- Inserts PADDING zeros at both ends of each row and advances by STRIDE.
- Each output beat holds exactly one complete window, so the pooling stage reduces it combinationally.
- Fully registered output, valid/ready on both sides.

---
 rtl/pool1d_window_buffer.sv | 104 ++++++++++
 1 files changed

// File: rtl/pool1d_window_buffer.sv
// Pads each row with zeros and slides a K-wide window over it; one window per output beat, registered 1 cycle after its completing advance.
// Output back-pressure blocks every advance (padding included), so windows are never dropped or duplicated.
module pool1d_window_buffer #(
   parameter int DATA_IN_0_PRECISION_0       = 8,
   parameter int DATA_IN_0_PRECISION_1       = 3,
   parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
   parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
   parameter int KERNEL_SIZE                 = 2,
   parameter int STRIDE                      = 2,
   parameter int PADDING                     = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0,
   input  logic                             data_in_0_valid,
   output logic                             data_in_0_ready,
   output logic [DATA_IN_0_PRECISION_0-1:0] data_out_0 [KERNEL_SIZE],
   output logic                             data_out_0_valid,
   input  logic                             data_out_0_ready
);
   localparam int W  = DATA_IN_0_PRECISION_0;
   localparam int L  = DATA_IN_0_TENSOR_SIZE_DIM_0;
   localparam int R  = DATA_IN_0_TENSOR_SIZE_DIM_1;
   localparam int K  = KERNEL_SIZE;
   localparam int S  = STRIDE;
   localparam int P  = PADDING;
   localparam int PL = L + 2 * P;
   localparam int PW = $clog2(PL + 1);
   localparam int RW = $clog2(R + 1);
   localparam int CW = $clog2(S + 1);

   localparam logic [PW-1:0] PRE_LAST  = PW'(P - 1);
   localparam logic [PW-1:0] FILL_LAST = PW'(P + L - 1);
   localparam logic [PW-1:0] POS_LAST  = PW'(PL - 1);
   localparam logic [PW-1:0] WIN_FIRST = PW'(K - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(R - 1);

   if (S < 1 || P >= K || PL < K || DATA_IN_0_PRECISION_1 > DATA_IN_0_PRECISION_0) begin : g_bad_params
      $error("pool1d_window_buffer: illegal parameter combination");
   end

   typedef enum logic [1:0] {PAD_PRE, FILL, PAD_POST} state_t;

   state_t        state;
   logic [PW-1:0] pos;
   logic [RW-1:0] row;
   logic [CW-1:0] gap_cnt;
   logic [W-1:0]  shreg     [K];
   logic [W-1:0]  shreg_nxt [K];
   logic [W-1:0]  elem;
   logic          advance_ok;
   logic          advance;
   logic          emit;

   assign advance_ok      = !data_out_0_valid || data_out_0_ready;
   assign data_in_0_ready = rst && (state == FILL) && advance_ok;
   assign advance         = (state == FILL) ? (data_in_0_valid && data_in_0_ready) : advance_ok;
   assign elem            = (state == FILL) ? data_in_0 : '0;
   // gap_cnt counts down the advances left until the next stride-aligned window
   assign emit            = advance && ((pos == WIN_FIRST) || (pos > WIN_FIRST && gap_cnt == '0));

   always_comb begin
      for (int j = 0; j < K - 1; j++) shreg_nxt[j] = shreg[j + 1];
      shreg_nxt[K - 1] = elem;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if (P > 0) state <= PAD_PRE;
         else       state <= FILL;
         pos     <= '0;
         row     <= '0;
         gap_cnt <= '0;
         for (int j = 0; j < K; j++) shreg[j] <= '0;
      end else if (advance) begin
         for (int j = 0; j < K; j++) shreg[j] <= shreg_nxt[j];
         if (emit)                gap_cnt <= CW'(S - 1);
         else if (gap_cnt != '0)  gap_cnt <= gap_cnt - CW'(1);
         if (pos == POS_LAST) begin
            pos <= '0;
            row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            if (P > 0) state <= PAD_PRE;
            else       state <= FILL;
         end else begin
            pos <= pos + PW'(1);
            if (state == PAD_PRE && pos == PRE_LAST) state <= FILL;
            if (state == FILL && pos == FILL_LAST)   state <= PAD_POST;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out_0_valid <= 1'b0;
         for (int j = 0; j < K; j++) data_out_0[j] <= '0;
      end else if (emit) begin
         data_out_0_valid <= 1'b1;
         for (int j = 0; j < K; j++) data_out_0[j] <= shreg_nxt[j];
      end else if (data_out_0_ready) begin
         data_out_0_valid <= 1'b0;
      end
   end

endmodule
